lsu_controller: RTL and testbench

- Multi-cycle load/store sequencer between the decode controller's memory signals (rd_en, wr_en, mem_mode) and a handshaked, word-addressed data-memory bus.
- Holds the core with a stall signal until the access completes.
- Generates byte enables and lane-aligned write data, and sign- or zero-extends load data.
- Flags misaligned, illegal and timed-out accesses so the single-cycle core can run against slow memory.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/lsu_controller_if.sv | 26 ++
 rtl/lsu_controller_lane_align.sv | 63 ++++++
 rtl/lsu_controller.sv | 172 +++++++++++++++++
 tb/tb_lsu_controller.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit: memory access modes,
// fault codes and the sequencer state encoding.
package riscv_pkg;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b011;
  localparam logic [2:0] MEM_HU = 3'b100;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ALIGN   = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQ       = 2'b01,
    WAIT_RESP = 2'b10,
    DONE      = 2'b11
  } lsu_state_t;

endpackage

// File: rtl/lsu_controller_if.sv
// Word-addressed, handshaked data-memory bus between the LSU (master)
// and the data memory (slave).
interface lsu_controller_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsu_controller_lane_align.sv
// Purely combinational lane handling for the LSU: legality/alignment
// check, byte-enable generation, store-data replication and load-data
// lane extraction with sign/zero extension.
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  input  logic [2:0]  ld_mode,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Decode the incoming request into byte enables, replicated store data and a legality flag
  always_comb begin
    legal      = 1'b1;
    be         = 4'b0000;
    wdata_lane = wdata;
    case (mem_mode)
      MEM_B, MEM_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      MEM_H, MEM_HU: begin
        be         = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        if (addr_lo[0]) legal = 1'b0;
      end
      MEM_W: begin
        be = 4'b1111;
        if (addr_lo != 2'b00) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (rd_en && wr_en) legal = 1'b0;
    if (wr_en && (mem_mode == MEM_BU || mem_mode == MEM_HU)) legal = 1'b0;
  end

  // Pick the addressed lane out of the returned word and extend it to 32 bits
  always_comb begin
    ld_byte = ld_raw[{ld_off, 3'b000} +: 8];
    ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_mode)
      MEM_B:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      MEM_BU:  ld_data = {24'h000000, ld_byte};
      MEM_H:   ld_data = {{16{ld_half[15]}}, ld_half};
      MEM_HU:  ld_data = {16'h0000, ld_half};
      MEM_W:   ld_data = ld_raw;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer. Stalls the single-cycle core while an
// access is in flight on the handshaked data bus, reports completion with
// a one-cycle done pulse and flags misaligned/illegal or timed-out accesses.
module lsu_controller
  import riscv_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        mem_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic [1:0]        fault,
  lsu_controller_if.master  bus
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  lsu_state_t  state;
  lsu_state_t  state_next;
  logic [15:0] tmo_cnt;
  logic [2:0]  ld_mode_q;
  logic [1:0]  ld_off_q;

  logic        legal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_data;
  logic        tmo_hit;

  logic        start_access;
  logic        start_illegal;
  logic        enter_wait;
  logic        finish_store;
  logic        finish_load;
  logic        finish_tmo;

  lsu_lane_align u_lane_align (
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .mem_mode   (mem_mode),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .legal      (legal),
    .be         (be_c),
    .wdata_lane (wdata_c),
    .ld_mode    (ld_mode_q),
    .ld_off     (ld_off_q),
    .ld_raw     (bus.rdata),
    .ld_data    (ld_data)
  );

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // State register; reset returns to IDLE so any in-flight access is abandoned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic plus the combinational stall and transition strobes
  always_comb begin
    state_next    = state;
    stall         = 1'b0;
    start_access  = 1'b0;
    start_illegal = 1'b0;
    enter_wait    = 1'b0;
    finish_store  = 1'b0;
    finish_load   = 1'b0;
    finish_tmo    = 1'b0;
    case (state)
      IDLE: begin
        if (rd_en || wr_en) begin
          if (legal) begin
            stall        = rst_n;
            start_access = 1'b1;
            state_next   = REQ;
          end else begin
            start_illegal = 1'b1;
            state_next    = DONE;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.gnt && bus.we) begin
          finish_store = 1'b1;
          state_next   = DONE;
        end else if (tmo_hit) begin
          finish_tmo = 1'b1;
          state_next = DONE;
        end else if (bus.gnt) begin
          enter_wait = 1'b1;
          state_next = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        stall = 1'b1;
        if (bus.rvalid) begin
          finish_load = 1'b1;
          state_next  = DONE;
        end else if (tmo_hit) begin
          finish_tmo = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus request registers, timeout counter and the registered completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.be    <= 4'b0000;
      bus.wdata <= 32'h0000_0000;
      rdata     <= 32'h0000_0000;
      done      <= 1'b0;
      fault     <= FAULT_NONE;
      tmo_cnt   <= 16'h0000;
      ld_mode_q <= 3'b000;
      ld_off_q  <= 2'b00;
    end else begin
      done <= 1'b0;
      if (state == REQ || state == WAIT_RESP) tmo_cnt <= tmo_cnt + 16'd1;
      if (start_access) begin
        bus.req   <= 1'b1;
        bus.we    <= wr_en;
        bus.addr  <= {addr[ADDR_W-1:2], 2'b00};
        bus.be    <= be_c;
        bus.wdata <= wdata_c;
        ld_mode_q <= mem_mode;
        ld_off_q  <= addr[1:0];
        tmo_cnt   <= 16'h0000;
      end
      if (enter_wait || finish_store || finish_tmo) bus.req <= 1'b0;
      if (start_illegal) begin
        done  <= 1'b1;
        fault <= FAULT_ALIGN;
        rdata <= 32'h0000_0000;
      end
      if (finish_store) begin
        done  <= 1'b1;
        fault <= FAULT_NONE;
        rdata <= 32'h0000_0000;
      end
      if (finish_load) begin
        done  <= 1'b1;
        fault <= FAULT_NONE;
        rdata <= ld_data;
      end
      if (finish_tmo) begin
        done  <= 1'b1;
        fault <= FAULT_TIMEOUT;
        rdata <= 32'h0000_0000;
      end
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: stimulus pushes expected bus
// requests and completions, a negedge monitor pops and compares them.
module tb_lsu_controller;
  import riscv_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic              wr_en = 1'b0;
  logic [2:0]        mem_mode = 3'b000;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = 32'h0;
  logic              stall;
  logic [31:0]       rdata;
  logic              done;
  logic [1:0]        fault;

  lsu_controller_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_controller #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .mem_mode (mem_mode),
    .addr     (addr),
    .wdata    (wdata),
    .stall    (stall),
    .rdata    (rdata),
    .done     (done),
    .fault    (fault),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          stall_cycles;
  } done_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_exp_t;

  done_exp_t done_q[$];
  bus_exp_t  bus_q[$];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: access size in bytes, 0 for an undefined mode
  function automatic int access_size(input logic [2:0] mode);
    case (mode)
      3'd0, 3'd3: return 1;
      3'd1, 3'd4: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_legal(input bit rd, input bit wr, input logic [2:0] mode, input logic [31:0] a);
    int sz;
    sz = access_size(mode);
    if (rd && wr) return 0;
    if (sz == 0) return 0;
    if (wr && (mode == 3'd3 || mode == 3'd4)) return 0;
    if ((int'(a[1:0]) % sz) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] mode, input logic [31:0] a);
    int tmp;
    tmp = ((1 << access_size(mode)) - 1) << int'(a[1:0]);
    return 4'(tmp);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] mode, input logic [31:0] w);
    case (access_size(mode))
      1:       return {24'h0, w[7:0]} * 32'h0101_0101;
      2:       return {16'h0, w[15:0]} * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] raw);
    int          sz;
    logic [31:0] v;
    logic [31:0] mask;
    sz = access_size(mode);
    v  = raw >> (int'(a[1:0]) * 8);
    if (sz == 4) return v;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v    = v & mask;
    if ((mode == 3'd0 || mode == 3'd1) && v > (mask >> 1)) v = v - (mask + 32'h1);
    return v;
  endfunction

  // Issue one access from decode and play the memory side with the given
  // grant delay g (REQ cycles before gnt) and response delay d (cycles after gnt)
  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] mode, input logic [31:0] a,
                               input logic [31:0] w, input int g, input int d, input logic [31:0] rdv);
    done_exp_t de;
    bus_exp_t  be;
    bit        lg;
    bit        got_done;
    bit        granted;
    int        req_k;
    int        wk;
    int        cyc;
    lg = model_legal(rd, wr, mode, a);
    de.rdata = 32'h0;
    if (!lg) begin
      de.fault = FAULT_ALIGN;
      de.stall_cycles = 0;
    end else if (wr) begin
      de.fault = (g < TIMEOUT) ? FAULT_NONE : FAULT_TIMEOUT;
      de.stall_cycles = (g < TIMEOUT) ? g + 2 : TIMEOUT + 1;
    end else if (g + d < TIMEOUT) begin
      de.fault = FAULT_NONE;
      de.rdata = model_load(mode, a, rdv);
      de.stall_cycles = g + d + 2;
    end else begin
      de.fault = FAULT_TIMEOUT;
      de.stall_cycles = TIMEOUT + 1;
    end
    done_q.push_back(de);
    if (lg) begin
      be.addr  = a & 32'hFFFF_FFFC;
      be.we    = wr;
      be.be    = model_be(mode, a);
      be.wdata = model_wdata(mode, w);
      bus_q.push_back(be);
    end
    rd_en = rd;
    wr_en = wr;
    mem_mode = mode;
    addr = a;
    wdata = w;
    got_done = 0;
    granted = 0;
    req_k = 0;
    wk = 0;
    cyc = 0;
    while (!got_done && cyc < 200) begin
      bus.gnt = 1'b0;
      bus.rvalid = 1'b0;
      if (granted) begin
        wk++;
        if (wk == d && !wr) begin
          bus.rvalid = 1'b1;
          bus.rdata = rdv;
        end
      end else if (bus.req) begin
        if (req_k == g) begin
          bus.gnt = 1'b1;
          granted = 1;
        end
        req_k++;
      end
      @(negedge clk);
      if (done) got_done = 1;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!got_done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_wait actual=no_done required=done_within_200_cycles");
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
  endtask

  int       stall_cnt = 0;
  logic     req_prev = 1'b0;
  bus_exp_t mon_b;
  done_exp_t mon_d;

  // Monitor: checks each new bus request and each completion against the queues
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_cnt = 0;
      req_prev = 1'b0;
    end else begin
      if (stall) stall_cnt++;
      if (bus.req && !req_prev) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_bus_req actual=1 required=0");
        end else begin
          mon_b = bus_q.pop_front();
          checkOutput("bus_addr", bus.addr, mon_b.addr);
          checkOutput("bus_we", 32'(bus.we), 32'(mon_b.we));
          checkOutput("bus_be", 32'(bus.be), 32'(mon_b.be));
          checkOutput("bus_wdata", bus.wdata, mon_b.wdata);
        end
      end
      req_prev = bus.req;
      if (done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 required=0");
        end else begin
          mon_d = done_q.pop_front();
          checkOutput("rdata", rdata, mon_d.rdata);
          checkOutput("fault", 32'(fault), 32'(mon_d.fault));
          checkOutput("stall_cycles", 32'(stall_cnt), 32'(mon_d.stall_cycles));
          checkOutput("stall_in_done", 32'(stall), 32'h0);
        end
        stall_cnt = 0;
      end
    end
  end

  // Absolute time limit so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed cases followed by randomized traffic
  initial begin
    bit          r_rd;
    bit          r_wr;
    int          sel;
    logic [2:0]  r_mode;
    logic [31:0] r_addr;
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_fault", 32'(fault), 32'h0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_bus_req", 32'(bus.req), 32'h0);
    checkOutput("rst_bus_we", 32'(bus.we), 32'h0);
    checkOutput("rst_bus_addr", bus.addr, 32'h0);
    checkOutput("rst_bus_be", 32'(bus.be), 32'h0);
    checkOutput("rst_bus_wdata", bus.wdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(0, 1, MEM_B,  32'h0000_1003, 32'h0000_00A5, 1, 1, 32'h0);
    applyStimulus(1, 0, MEM_B,  32'h0000_2001, 32'h0,         0, 3, 32'h1234_8056);
    applyStimulus(1, 0, MEM_BU, 32'h0000_2001, 32'h0,         0, 3, 32'h1234_8056);
    applyStimulus(1, 0, MEM_H,  32'h0000_2002, 32'h0,         1, 2, 32'h8000_1234);
    applyStimulus(1, 0, MEM_HU, 32'h0000_2002, 32'h0,         1, 2, 32'h8000_1234);
    applyStimulus(1, 0, MEM_W,  32'h0000_3002, 32'h0,         0, 1, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 3'b110, 32'h0000_3000, 32'h0,         0, 1, 32'hDEAD_BEEF);
    applyStimulus(1, 1, MEM_W,  32'h0000_3000, 32'h0,         0, 1, 32'hDEAD_BEEF);
    applyStimulus(1, 0, MEM_W,  32'h0000_3000, 32'h0,      1000, 1, 32'hDEAD_BEEF);
    applyStimulus(0, 1, MEM_H,  32'h0000_3006, 32'h1357_BEEF, 7, 1, 32'h0);
    applyStimulus(1, 0, MEM_W,  32'h0000_3008, 32'h0,         4, 3, 32'hCAFE_F00D);

    rd_en = 1'b1;
    mem_mode = MEM_W;
    addr = 32'h0000_5000;
    mon_b.addr = 32'h0000_5000;
    mon_b.we = 1'b0;
    mon_b.be = 4'b1111;
    mon_b.wdata = 32'h0;
    wdata = 32'h0;
    bus_q.push_back(mon_b);
    @(posedge clk);
    #1;
    bus.gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.gnt = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("wait_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_bus_req", 32'(bus.req), 32'h0);
    checkOutput("mid_rst_stall", 32'(stall), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mid_rst_done", 32'(done), 32'h0);
    end
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(0, 1, MEM_W, 32'h0000_4000, 32'h8765_4321, 0, 1, 32'h0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      r_rd = (sel <= 4) || (sel == 9);
      r_wr = (sel >= 5);
      if ($urandom_range(0, 7) == 0) r_mode = 3'($urandom_range(5, 7));
      else                           r_mode = 3'($urandom_range(0, 4));
      r_addr = $urandom;
      applyStimulus(r_rd, r_wr, r_mode, r_addr, $urandom, $urandom_range(0, 9),
                    $urandom_range(1, 5), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("done_q_empty", 32'(done_q.size()), 32'h0);
    checkOutput("bus_q_empty", 32'(bus_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
